// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular-priority picker: first eligible request at or after i_ptr.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic [N-1:0]    i_excl,
  output logic [N-1:0]    o_pick,
  output logic [ID_W-1:0] o_pick_id,
  output logic            o_pick_valid
);

  logic [N-1:0] w_elig;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_oh;

  assign w_elig       = i_req & ~i_excl;
  assign o_pick_valid = |w_elig;

  // Rotate so i_ptr lands on bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    w_rot     = '0;
    o_pick    = '0;
    o_pick_id = '0;
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = j + int'(i_ptr);
      if (idx >= N) idx = idx - N;
      w_rot[j] = w_elig[idx];
    end
    w_rot_oh = w_rot & (~w_rot + N'(1));
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = j + int'(i_ptr);
      if (idx >= N) idx = idx - N;
      if (w_rot_oh[j]) begin
        o_pick[idx] = 1'b1;
        o_pick_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered, locked grants.
// Define ARB_TIMEOUT_EN to add a MAX_HOLD grant limit and the timeout pulse port.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int ID_W     = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);

  if (N < 2 || N > MAX_N || MAX_HOLD < 2 || ID_W != $clog2(N)) begin : g_bad_cfg
    $error("rr_arbiter: illegal parameter combination");
  end

  arb_state_t      r_state, w_state_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;
  logic [ID_W-1:0] r_gnt_id, w_id_nxt;
  logic [ID_W-1:0] r_ptr, w_ptr_nxt;
  logic            w_new_grant;

  logic            w_owner_req;
  logic            w_force;
  logic            w_release;
  logic [ID_W-1:0] w_pick_ptr;
  logic [N-1:0]    w_excl;
  logic [N-1:0]    w_pick;
  logic [ID_W-1:0] w_pick_id;
  logic            w_pick_valid;

  assign w_owner_req = |(req & r_gnt);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  assign w_force = (r_state == BUSY) && w_owner_req && (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
  assign w_force = 1'b0;
`endif

  assign w_release = (r_state == BUSY) && (!w_owner_req || w_force);

  // On release the search already uses the advanced pointer and skips the old owner.
  assign w_pick_ptr = w_release ? ID_W'(next_ptr(int'(r_gnt_id), N)) : r_ptr;
  assign w_excl     = w_release ? r_gnt : '0;

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .i_req        (req),
    .i_ptr        (w_pick_ptr),
    .i_excl       (w_excl),
    .o_pick       (w_pick),
    .o_pick_id    (w_pick_id),
    .o_pick_valid (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_gnt_id;
    w_ptr_nxt   = r_ptr;
    w_new_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = w_pick;
          w_id_nxt    = w_pick_id;
          w_new_grant = 1'b1;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_pick_ptr;
          if (w_pick_valid) begin
            w_gnt_nxt   = w_pick;
            w_id_nxt    = w_pick_id;
            w_new_grant = 1'b1;
          end else begin
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_id_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (w_new_grant || w_release) begin
        r_hold <= '0;
      end else if (r_state == BUSY) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign timeout = r_timeout;
`endif

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = |r_gnt;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter; timeout checks are compiled in with ARB_TIMEOUT_EN.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] id;
    logic            to;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic            timeout;
`endif

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb_q[$];

  int m_owner;
  int m_ptr;
  int m_hold;
  int m_last;

  rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int search(input logic [N-1:0] r, input int p, input int ex);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx] && idx != ex) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_last  = 0;
  endtask

  // m_hold counts grant cycles already shown, including the current one.
  task automatic model_step(input logic [N-1:0] r, output exp_t e);
    bit forced;
    int w;
    forced = 1'b0;
    e.to   = 1'b0;
    if (m_owner < 0) begin
      w = search(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
        m_last  = w;
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      forced = r[m_owner] && (m_hold >= MAX_HOLD);
`endif
      if (r[m_owner] && !forced) begin
        m_hold++;
      end else begin
        m_ptr = (m_owner + 1) % N;
        w     = search(r, m_ptr, m_owner);
        e.to  = forced;
        if (w >= 0) begin
          m_owner = w;
          m_hold  = 1;
          m_last  = w;
        end else begin
          m_owner = -1;
        end
      end
    end
    e.gnt = '0;
    if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
    e.id = ID_W'(m_last);
  endtask

  task automatic step(input logic [N-1:0] r);
    exp_t e;
    req = r;
    model_step(r, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("gnt", 32'(gnt), 32'(e.gnt));
    chk("gnt_valid", 32'(gnt_valid), 32'(|e.gnt));
    chk("gnt_id", 32'(gnt_id), 32'(e.id));
`ifdef ARB_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(e.to));
`endif
  endtask

  initial begin
    logic [N-1:0] r;
    int n_to;

    rst_n = 1'b0;
    req   = '1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;

    // single request and release
    step(4'b0000);
    step(4'b0001);
    chk("t2_grant", 32'(gnt), 32'h1);
    step(4'b0001);
    step(4'b0000);
    chk("t2_release", 32'(gnt_valid), 32'h0);

    // asynchronous reset while a grant is held
    step(4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_valid", 32'(gnt_valid), 32'h0);
    chk("midrst_id", 32'(gnt_id), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // fairness: 0,1,2,3,0 with zero-bubble handovers
    step(4'b1111);
    chk("t3_first", 32'(gnt), 32'h1);
    for (int i = 0; i < N; i++) begin
      step(4'b1111);
      step(4'b1111);
      step(4'hF & ~(4'b0001 << i));
      chk("t3_handover", 32'(gnt), 32'(1) << ((i + 1) % N));
    end

    // wrap and exclusion
    step(4'b1000);
    chk("t4_to3", 32'(gnt), 32'h8);
    step(4'b0011);
    chk("t4_wrap", 32'(gnt), 32'h1);
    step(4'b0010);
    chk("t4_to1", 32'(gnt), 32'h2);
    step(4'b0000);
    chk("t4_idle", 32'(gnt_valid), 32'h0);
    chk("t4_id_hold", 32'(gnt_id), 32'h1);

    // lock: owner 2 keeps the grant while others toggle
    step(4'b0100);
    for (int k = 0; k < 6; k++) begin
      step((k % 2 == 0) ? 4'b1101 : 4'b0111);
      chk("t5_lock", 32'(gnt), 32'h4);
    end
    step(4'b0000);

`ifdef ARB_TIMEOUT_EN
    n_to = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0100);
      if (timeout) n_to++;
    end
    chk("t6_pulses", 32'(n_to), 32'd2);
    step(4'b0000);
`else
    n_to = 0;
`endif

    // random traffic, requests mostly sticky
    r = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      step(r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
